// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the
// instruction-fetch requester (IF) and the load/store requester (D).
// Each transaction is sequenced IDLE -> GNT_x -> DONE -> IDLE. Stores get
// lane strobes and replicated data, and loads are lane-selected and
// sign/zero-extended from func3. Misaligned data accesses complete
// without touching memory.
// Optional feature: define ARB_TIMEOUT_EN to abort a granted transaction
// after TIMEOUT cycles without mem_ready. The abort pulses arb_err and
// returns zero data.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_misaligned,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        arb_err
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Access size encoding: 0 = byte, 1 = half, 2 = word (undefined func3 -> word)
  function automatic logic [1:0] accessSize(input logic we, input logic [2:0] func3);
    logic [1:0] size;
    if (we) begin
      case (func3)
        3'd0:    size = 2'd0;
        3'd1:    size = 2'd1;
        default: size = 2'd2;
      endcase
    end else begin
      case (func3)
        3'd0, 3'd4: size = 2'd0;
        3'd1, 3'd5: size = 2'd1;
        default:    size = 2'd2;
      endcase
    end
    return size;
  endfunction

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      2'd1:    mis = lane[0];
      2'd2:    mis = (lane != 2'd0);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] storeStrb(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << lane;
      2'd1:    strb = 4'b0011 << lane;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] storeData(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] data;
    case (size)
      2'd0:    data = {4{wdata[7:0]}};
      2'd1:    data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

  // Lane select plus extension; func3 values other than lb/lh/lbu/lhu yield the whole word
  function automatic logic [31:0] extendLoad(input logic [31:0] word, input logic [2:0] func3,
                                             input logic [1:0] lane);
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] result;
    byteVal = word[{lane, 3'b000} +: 8];
    halfVal = lane[1] ? word[31:16] : word[15:0];
    case (func3)
      3'd0:    result = {{24{byteVal[7]}}, byteVal};
      3'd1:    result = {{16{halfVal[15]}}, halfVal};
      3'd4:    result = {24'h000000, byteVal};
      3'd5:    result = {16'h0000, halfVal};
      default: result = word;
    endcase
    return result;
  endfunction

  state_t               state_r;
  state_t               stateNext_s;
  logic                 grantIf_s;
  logic                 grantD_s;
  logic                 complete_s;
  logic                 timeout_s;
  logic                 toExpired_s;
  logic                 dMis_s;
  logic [1:0]           dSize_s;
  logic [STREAK_W-1:0]  streak_r;
  logic                 ownerIsD_r;
  logic                 dIsStore_r;
  logic [1:0]           dLane_r;
  logic [2:0]           dFunc3_r;
  logic                 unusedBits_s;

  assign dSize_s   = accessSize(d_we, d_func3);
  assign dMis_s    = isMisaligned(dSize_s, d_addr[1:0]);
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Arbitration and next-state decode
  always_comb begin
    stateNext_s = state_r;
    grantIf_s   = 1'b0;
    grantD_s    = 1'b0;
    complete_s  = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_req && d_req) begin
          if (streak_r == STREAK_W'(MAX_D_STREAK)) begin
            grantIf_s = 1'b1;
          end else begin
            grantD_s = 1'b1;
          end
        end else if (if_req) begin
          grantIf_s = 1'b1;
        end else if (d_req) begin
          grantD_s = 1'b1;
        end else begin
          grantIf_s = 1'b0;
        end
        if (grantIf_s) begin
          stateNext_s = GNT_IF;
        end else if (grantD_s) begin
          stateNext_s = dMis_s ? DONE : GNT_D;
        end else begin
          stateNext_s = IDLE;
        end
      end
      GNT_IF, GNT_D: begin
        if (mem_ready) begin
          complete_s  = 1'b1;
          stateNext_s = DONE;
        end else if (toExpired_s) begin
          timeout_s   = 1'b1;
          stateNext_s = DONE;
        end else begin
          stateNext_s = state_r;
        end
      end
      DONE:    stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // Data-streak counter: lets IF win after MAX_D_STREAK consecutive D grants it waited through
  always_ff @(posedge clk) begin
    if (!reset) begin
      streak_r <= {STREAK_W{1'b0}};
    end else if (!if_req || grantIf_s) begin
      streak_r <= {STREAK_W{1'b0}};
    end else if (grantD_s) begin
      streak_r <= streak_r + STREAK_W'(1);
    end else begin
      streak_r <= streak_r;
    end
  end

  // Memory port, captured request attributes and completion outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      mem_wstrb    <= 4'h0;
      if_rdata     <= 32'h0;
      if_valid     <= 1'b0;
      d_rdata      <= 32'h0;
      d_valid      <= 1'b0;
      d_misaligned <= 1'b0;
      ownerIsD_r   <= 1'b0;
      dIsStore_r   <= 1'b0;
      dLane_r      <= 2'd0;
      dFunc3_r     <= 3'd0;
    end else begin
      if_valid     <= 1'b0;
      d_valid      <= 1'b0;
      d_misaligned <= 1'b0;
      if (grantIf_s) begin
        ownerIsD_r <= 1'b0;
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= {if_addr[31:2], 2'b00};
        mem_wdata  <= 32'h0;
        mem_wstrb  <= 4'h0;
      end else if (grantD_s) begin
        ownerIsD_r <= 1'b1;
        dIsStore_r <= d_we;
        dLane_r    <= d_addr[1:0];
        dFunc3_r   <= d_func3;
        if (dMis_s) begin
          // Rejected access: memory is left untouched
          d_valid      <= 1'b1;
          d_misaligned <= 1'b1;
          d_rdata      <= 32'h0;
        end else begin
          mem_req   <= 1'b1;
          mem_we    <= d_we;
          mem_addr  <= {d_addr[31:2], 2'b00};
          mem_wdata <= d_we ? storeData(dSize_s, d_wdata) : 32'h0;
          mem_wstrb <= d_we ? storeStrb(dSize_s, d_addr[1:0]) : 4'h0;
        end
      end else if (complete_s || timeout_s) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_wstrb <= 4'h0;
        if (ownerIsD_r) begin
          d_valid <= 1'b1;
          if (complete_s && !dIsStore_r) begin
            d_rdata <= extendLoad(mem_rdata, dFunc3_r, dLane_r);
          end else begin
            d_rdata <= 32'h0;
          end
        end else begin
          if_valid <= 1'b1;
          if_rdata <= complete_s ? mem_rdata : 32'h0;
        end
      end else begin
        mem_req <= mem_req;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] toCnt_r;

  assign toExpired_s  = (toCnt_r == TO_W'(TIMEOUT - 1));
  assign unusedBits_s = ^if_addr[1:0];

  // Wait counter for a granted transaction and the abort error pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      toCnt_r <= {TO_W{1'b0}};
      arb_err <= 1'b0;
    end else begin
      arb_err <= timeout_s;
      if ((state_r == GNT_IF || state_r == GNT_D) && !complete_s && !timeout_s) begin
        toCnt_r <= toCnt_r + TO_W'(1);
      end else begin
        toCnt_r <= {TO_W{1'b0}};
      end
    end
  end
`else
  assign toExpired_s  = 1'b0;
  assign arb_err      = 1'b0;
  assign unusedBits_s = ^{if_addr[1:0], (TIMEOUT > 0)};
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Memory model: mem_ready follows mem_req after waitCycles cycles.
// memReadyEn = 0 stalls the memory completely.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_func3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_misaligned;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        arb_err;

  logic        memReadyEn = 1'b1;
  int          waitCycles = 0;
  int          waitCnt = 0;

  int passCnt = 0;
  int totalCnt = 0;

  // Results of the last runD transaction
  logic        rValid;
  logic        rSawReq;
  logic [31:0] rAddr;
  logic [31:0] rWdata;
  logic [3:0]  rStrb;
  logic        rWe;
  logic [31:0] rRdata;
  logic        rMis;
  int          rCycles;
  logic        rStallOk;

  mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_misaligned(d_misaligned),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  // Memory wait-state model
  always @(posedge clk) begin
    if (mem_req && !mem_ready) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end
  assign mem_ready = memReadyEn && mem_req && (waitCnt >= waitCycles);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passCnt++;
  endtask

  // One data transaction, held until d_valid or a 50-cycle bound
  task automatic runD(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata);
    d_req = 1'b1; d_we = we; d_func3 = f3; d_addr = addr; d_wdata = wdata;
    rValid = 1'b0; rSawReq = 1'b0; rCycles = 0; rStallOk = 1'b1;
    rAddr = 32'h0; rWdata = 32'h0; rStrb = 4'h0; rWe = 1'b0; rRdata = 32'hDEADBEEF; rMis = 1'b0;
    for (int i = 0; i < 50 && !rValid; i++) begin
      tick();
      rCycles++;
      if (mem_req && !rSawReq) begin
        rSawReq = 1'b1; rAddr = mem_addr; rWdata = mem_wdata; rStrb = mem_wstrb; rWe = mem_we;
      end
      if (d_valid) begin
        rValid = 1'b1; rRdata = d_rdata; rMis = d_misaligned;
        if (stall_mem !== 1'b0) rStallOk = 1'b0;
      end else if (stall_mem !== 1'b1) begin
        rStallOk = 1'b0;
      end
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    chk("reset_mem_req", {31'h0, mem_req}, 32'h0);
    chk("reset_valids", {29'h0, if_valid, d_valid, d_misaligned}, 32'h0);
    chk("reset_arb_err", {31'h0, arb_err}, 32'h0);
    chk("reset_if_rdata", if_rdata, 32'h0);
    // Enter GNT_D with a stalled memory, then reset mid-transaction
    reset = 1'b1; memReadyEn = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_func3 = 3'd2; d_addr = 32'h40;
    tick();
    chk("gnt_d_mem_req", {31'h0, mem_req}, 32'h1);
    reset = 1'b0; d_req = 1'b0;
    tick();
    chk("midreset_dvalid1", {31'h0, d_valid}, 32'h0);
    tick();
    chk("midreset_mem_req", {31'h0, mem_req}, 32'h0);
    chk("midreset_dvalid2", {31'h0, d_valid}, 32'h0);
    reset = 1'b1; memReadyEn = 1'b1; mem_rdata = 32'h00500093;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    chk("if_c1_valid", {31'h0, if_valid}, 32'h0);
    chk("if_c1_mem_addr", mem_addr, 32'h100);
    chk("if_c1_stall_if", {31'h0, stall_if}, 32'h1);
    tick();
    chk("if_c2_valid", {31'h0, if_valid}, 32'h1);
    chk("if_rdata", if_rdata, 32'h00500093);
    if_req = 1'b0;
    tick();
    chk("if_valid_one_cycle", {31'h0, if_valid}, 32'h0);
  endtask

  task automatic test_store();
    runD(1'b1, 3'd0, 32'h203, 32'h000000AB);
    chk("sb_valid", {31'h0, rValid}, 32'h1);
    chk("sb_latency", rCycles, 32'd2);
    chk("sb_addr", rAddr, 32'h200);
    chk("sb_strb", {28'h0, rStrb}, 32'h8);
    chk("sb_wdata", rWdata, 32'hABABABAB);
    chk("sb_we", {31'h0, rWe}, 32'h1);
    chk("sb_stall_mem", {31'h0, rStallOk}, 32'h1);
    runD(1'b1, 3'd1, 32'h302, 32'hFFFF1234);
    chk("sh_strb", {28'h0, rStrb}, 32'hC);
    chk("sh_wdata", rWdata, 32'h12341234);
    runD(1'b1, 3'd2, 32'h304, 32'hCAFEF00D);
    chk("sw_strb", {28'h0, rStrb}, 32'hF);
    chk("sw_wdata", rWdata, 32'hCAFEF00D);
  endtask

  task automatic test_load_ext();
    mem_rdata = 32'h0000F000;
    runD(1'b0, 3'd0, 32'h201, 32'h0);
    chk("lb_rdata", rRdata, 32'hFFFFFFF0);
    chk("lb_addr", rAddr, 32'h200);
    chk("lb_we_strb", {27'h0, rWe, rStrb}, 32'h0);
    runD(1'b0, 3'd4, 32'h201, 32'h0);
    chk("lbu_rdata", rRdata, 32'h000000F0);
    mem_rdata = 32'h80010000;
    runD(1'b0, 3'd1, 32'h202, 32'h0);
    chk("lh_rdata", rRdata, 32'hFFFF8001);
    runD(1'b0, 3'd5, 32'h202, 32'h0);
    chk("lhu_rdata", rRdata, 32'h00008001);
    runD(1'b0, 3'd7, 32'h204, 32'h0);
    chk("undef_f3_word", rRdata, 32'h80010000);
  endtask

  task automatic test_misaligned();
    runD(1'b0, 3'd2, 32'h102, 32'h0);
    chk("lw_mis_no_req", {31'h0, rSawReq}, 32'h0);
    chk("lw_mis_flags", {30'h0, rValid, rMis}, 32'h3);
    chk("lw_mis_latency", rCycles, 32'd1);
    chk("lw_mis_rdata", rRdata, 32'h0);
    runD(1'b1, 3'd1, 32'h201, 32'h1234);
    chk("sh_mis_flags", {29'h0, rSawReq, rValid, rMis}, 32'h3);
  endtask

  task automatic test_wait_states();
    waitCycles = 3; mem_rdata = 32'h13572468;
    runD(1'b0, 3'd2, 32'h100, 32'h0);
    chk("wait_latency", rCycles, 32'd5);
    chk("wait_rdata", rRdata, 32'h13572468);
    waitCycles = 0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] order;
    int         nGr;
    logic       prevReq;
    logic       stallOk;
    logic       ifDone;
    order = 6'h0; nGr = 0; prevReq = 1'b0; stallOk = 1'b1; ifDone = 1'b0;
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_func3 = 3'd2; d_addr = 32'h400;
    for (int i = 0; i < 60 && nGr < 6; i++) begin
      tick();
      if (mem_req && !prevReq) begin
        order = {order[4:0], (mem_addr == 32'h400)};
        nGr++;
      end
      prevReq = mem_req;
      if (if_valid) ifDone = 1'b1;
      else if (!ifDone && stall_if !== 1'b1) stallOk = 1'b0;
    end
    chk("grant_order", {26'h0, order}, 32'h3D);
    chk("stall_if_held", {31'h0, stallOk}, 32'h1);
    chk("if_served", {31'h0, ifDone}, 32'h1);
    if_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int riseAt;
    int validAt;
    int errAt;
    riseAt = -1; validAt = -1; errAt = -1;
    memReadyEn = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_func3 = 3'd2; d_addr = 32'h80;
    for (int i = 1; i <= 40 && validAt < 0; i++) begin
      tick();
      if (mem_req && riseAt < 0) riseAt = i;
      if (arb_err && errAt < 0) errAt = i;
      if (d_valid) validAt = i;
    end
    d_req = 1'b0;
    chk("to_valid_delay", validAt - riseAt, 32'd8);
    chk("to_err_with_valid", errAt, validAt);
    chk("to_rdata", d_rdata, 32'h0);
    chk("to_mem_req_drop", {31'h0, mem_req}, 32'h0);
    tick();
    chk("to_err_one_cycle", {31'h0, arb_err}, 32'h0);
    memReadyEn = 1'b1;
    tick();
  endtask
`else
  task automatic test_timeout();
    logic anyValid;
    logic anyErr;
    anyValid = 1'b0; anyErr = 1'b0;
    memReadyEn = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_func3 = 3'd2; d_addr = 32'h80;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (d_valid) anyValid = 1'b1;
      if (arb_err) anyErr = 1'b1;
    end
    chk("nto_still_waiting", {31'h0, mem_req}, 32'h1);
    chk("nto_no_valid", {31'h0, anyValid}, 32'h0);
    chk("nto_no_err", {31'h0, anyErr}, 32'h0);
    d_req = 1'b0; reset = 1'b0;
    tick(); tick();
    reset = 1'b1; memReadyEn = 1'b1;
    tick();
  endtask
`endif

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_func3 = 3'd0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_rdata = 32'h0;
    test_reset();
    test_store();
    test_load_ext();
    test_misaligned();
    test_wait_states();
    test_back_to_back();
    test_timeout();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
